// File: rtl/controlador_turnos_pkg.sv
// Shared types for the two-player turn sequencer: FSM state encoding and winner codes.
package controlador_turnos_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        TURN   = 3'd2,
        CHECK  = 3'd3,
        RESULT = 3'd4,
        AUTO   = 3'd5
    } state_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

endpackage

// File: rtl/controlador_turnos_retardo.sv
// retardo_ciclos: cycle timer; o_done rises on the CYCLES-th consecutive enabled cycle.
// The count clears whenever i_enable is low and saturates at CYCLES.
module retardo_ciclos #(
    parameter int unsigned CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_done
);

    localparam int unsigned CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0] TERM = CW'(CYCLES);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_enable) begin
            r_cnt <= '0;
        end else if (r_cnt != TERM) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_done = i_enable && (r_cnt >= LAST);

endmodule

// File: rtl/controlador_turnos.sv
// Two-player turn sequencer: board clear, per-turn time limit, move check, result hold.
// Optional macro CT_AUTOMOVE_EN: a timed-out turn waits in AUTO for a generated move.
module controlador_turnos
    import controlador_turnos_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 25_175_000,
    parameter int unsigned TURN_SECONDS  = 10,
    parameter int unsigned RESULT_CYCLES = 50_350_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       move_valid,
    input  logic       win_detected,
    input  logic       draw_detected,
    output logic       board_clear,
    output logic       player,
    output logic       turn_active,
    output logic [3:0] time_left_s,
    output logic       timeout_pulse,
    output logic       show_result,
    output logic [1:0] winner,
    output logic [2:0] state_o,
    output logic       auto_move_req
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [3:0]    TS       = 4'(TURN_SECONDS);

    state_t        r_state, w_state_n;
    logic          r_player, w_player_n;
    logic [3:0]    r_time_left, w_time_left_n;
    logic [PW-1:0] r_prescaler, w_prescaler_n;
    logic [1:0]    r_winner, w_winner_n;
    logic          r_board_clear, r_timeout_pulse, w_timeout_n;
    logic          r_show_result, r_turn_active;
    logic          w_pre_wrap, w_hold_done;

    retardo_ciclos #(.CYCLES(RESULT_CYCLES)) u_hold (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_enable (r_state == RESULT),
        .o_done   (w_hold_done)
    );

    assign w_pre_wrap = (r_prescaler == PRE_LAST);

    always_comb begin
        w_state_n     = r_state;
        w_player_n    = r_player;
        w_time_left_n = r_time_left;
        w_prescaler_n = r_prescaler;
        w_winner_n    = r_winner;
        w_timeout_n   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_n  = CLEAR;
                    w_winner_n = W_NONE;
                end
            end
            CLEAR: begin
                w_player_n    = 1'b0;
                w_time_left_n = TS;
                w_prescaler_n = '0;
                w_state_n     = TURN;
            end
            TURN: begin
                // A move landing on the expiry cycle takes precedence over the timeout.
                if (move_valid) begin
                    w_state_n     = CHECK;
                    w_prescaler_n = '0;
                end else if (w_pre_wrap) begin
                    w_prescaler_n = '0;
                    if (r_time_left <= 4'd1) begin
                        w_timeout_n = 1'b1;
`ifdef CT_AUTOMOVE_EN
                        w_state_n     = AUTO;
                        w_time_left_n = '0;
`else
                        w_player_n    = ~r_player;
                        w_time_left_n = TS;
`endif
                    end else begin
                        w_time_left_n = r_time_left - 4'd1;
                    end
                end else begin
                    w_prescaler_n = r_prescaler + PW'(1);
                end
            end
            CHECK: begin
                if (win_detected) begin
                    w_state_n  = RESULT;
                    w_winner_n = r_player ? W_P2 : W_P1;
                end else if (draw_detected) begin
                    w_state_n  = RESULT;
                    w_winner_n = W_DRAW;
                end else begin
                    w_state_n     = TURN;
                    w_player_n    = ~r_player;
                    w_time_left_n = TS;
                    w_prescaler_n = '0;
                end
            end
            RESULT: begin
                if (w_hold_done) begin
                    w_state_n = IDLE;
                end
            end
`ifdef CT_AUTOMOVE_EN
            AUTO: begin
                if (move_valid) begin
                    w_state_n = CHECK;
                end
            end
`endif
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_player        <= 1'b0;
            r_time_left     <= '0;
            r_prescaler     <= '0;
            r_winner        <= W_NONE;
            r_board_clear   <= 1'b0;
            r_timeout_pulse <= 1'b0;
            r_show_result   <= 1'b0;
            r_turn_active   <= 1'b0;
        end else begin
            r_state         <= w_state_n;
            r_player        <= w_player_n;
            r_time_left     <= w_time_left_n;
            r_prescaler     <= w_prescaler_n;
            r_winner        <= w_winner_n;
            r_board_clear   <= (w_state_n == CLEAR);
            r_timeout_pulse <= w_timeout_n;
            r_show_result   <= (w_state_n == RESULT);
            r_turn_active   <= (w_state_n == TURN) || (w_state_n == AUTO);
        end
    end

`ifdef CT_AUTOMOVE_EN
    logic r_auto_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_auto_req <= 1'b0;
        end else begin
            r_auto_req <= (w_state_n == AUTO);
        end
    end

    assign auto_move_req = r_auto_req;
`else
    assign auto_move_req = 1'b0;
`endif

    assign board_clear   = r_board_clear;
    assign player        = r_player;
    assign turn_active   = r_turn_active;
    assign time_left_s   = r_time_left;
    assign timeout_pulse = r_timeout_pulse;
    assign show_result   = r_show_result;
    assign winner        = r_winner;
    assign state_o       = r_state;

endmodule

// File: tb/tb_controlador_turnos.sv
// Directed bench for controlador_turnos with CLK_HZ=4, TURN_SECONDS=3, RESULT_CYCLES=5.
// Build with CT_AUTOMOVE_EN defined to exercise the AUTO path instead of turn forfeit.
module tb_controlador_turnos;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       move_valid = 1'b0;
    logic       win_detected = 1'b0;
    logic       draw_detected = 1'b0;
    logic       board_clear, player, turn_active, timeout_pulse, show_result, auto_move_req;
    logic [3:0] time_left_s;
    logic [1:0] winner;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_err = 0;

    controlador_turnos #(
        .CLK_HZ        (4),
        .TURN_SECONDS  (3),
        .RESULT_CYCLES (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .move_valid    (move_valid),
        .win_detected  (win_detected),
        .draw_detected (draw_detected),
        .board_clear   (board_clear),
        .player        (player),
        .turn_active   (turn_active),
        .time_left_s   (time_left_s),
        .timeout_pulse (timeout_pulse),
        .show_result   (show_result),
        .winner        (winner),
        .state_o       (state_o),
        .auto_move_req (auto_move_req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #12;
        chk("rst_state", 8'(state_o), 8'd0);
        chk("rst_player", 8'(player), 8'd0);
        chk("rst_winner", 8'(winner), 8'd0);
        chk("rst_time", 8'(time_left_s), 8'd0);
        chk("rst_levels", {2'b0, board_clear, turn_active, timeout_pulse, show_result, auto_move_req, 1'b0}, 8'd0);
        reset = 1'b0;

        // start -> CLEAR for one cycle -> TURN
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("clear_state", 8'(state_o), 8'd1);
        chk("clear_pulse", 8'(board_clear), 8'd1);
        tick();
        chk("turn_state", 8'(state_o), 8'd2);
        chk("turn_clear_low", 8'(board_clear), 8'd0);
        chk("turn_player", 8'(player), 8'd0);
        chk("turn_time0", 8'(time_left_s), 8'd3);
        chk("turn_active", 8'(turn_active), 8'd1);
        repeat (3) tick();
        chk("time_before_wrap", 8'(time_left_s), 8'd3);
        tick();
        chk("time_after_4", 8'(time_left_s), 8'd2);

        // Run to cycle 12 of the turn with no move
        repeat (7) tick();
        chk("cyc12_time", 8'(time_left_s), 8'd1);
        chk("cyc12_no_pulse", 8'(timeout_pulse), 8'd0);
        tick();
        chk("timeout_pulse", 8'(timeout_pulse), 8'd1);
`ifdef CT_AUTOMOVE_EN
        chk("auto_state", 8'(state_o), 8'd5);
        chk("auto_req", 8'(auto_move_req), 8'd1);
        chk("auto_time", 8'(time_left_s), 8'd0);
        chk("auto_active", 8'(turn_active), 8'd1);
        repeat (6) tick();
        chk("auto_req_held", 8'(auto_move_req), 8'd1);
        chk("auto_pulse_once", 8'(timeout_pulse), 8'd0);
        move_valid = 1'b1; tick(); move_valid = 1'b0;
        chk("auto_to_check", 8'(state_o), 8'd3);
        chk("auto_req_drop", 8'(auto_move_req), 8'd0);
        tick();
        chk("auto_next_player", 8'(player), 8'd1);
        chk("auto_next_time", 8'(time_left_s), 8'd3);
`else
        chk("forfeit_player", 8'(player), 8'd1);
        chk("forfeit_time", 8'(time_left_s), 8'd3);
        chk("forfeit_state", 8'(state_o), 8'd2);
        chk("no_auto_req", 8'(auto_move_req), 8'd0);
        tick();
        chk("timeout_one_cycle", 8'(timeout_pulse), 8'd0);
`endif

        // Move without win/draw: CHECK then TURN with the other player
        move_valid = 1'b1; tick(); move_valid = 1'b0;
        chk("mv_check", 8'(state_o), 8'd3);
        chk("mv_check_inactive", 8'(turn_active), 8'd0);
        tick();
        chk("mv_back_turn", 8'(state_o), 8'd2);
        chk("mv_toggle", 8'(player), 8'd0);
        chk("mv_time_reload", 8'(time_left_s), 8'd3);

        // start during TURN is ignored
        start = 1'b1; tick(); start = 1'b0;
        chk("start_ignored", 8'(state_o), 8'd2);
        chk("start_no_clear", 8'(board_clear), 8'd0);

        // P1 wins; result held exactly 5 cycles
        move_valid = 1'b1; tick(); move_valid = 1'b0;
        win_detected = 1'b1; tick(); win_detected = 1'b0;
        chk("win_state", 8'(state_o), 8'd4);
        chk("win_p1", 8'(winner), 8'd1);
        chk("show_1", 8'(show_result), 8'd1);
        repeat (4) tick();
        chk("show_5", 8'(show_result), 8'd1);
        tick();
        chk("result_done", 8'(state_o), 8'd0);
        chk("show_low", 8'(show_result), 8'd0);
        chk("winner_kept", 8'(winner), 8'd1);
        move_valid = 1'b1; tick(); move_valid = 1'b0;
        chk("move_idle_ignored", 8'(state_o), 8'd0);

        // Move on the timeout cycle: no pulse, CHECK taken, draw
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_winner_clr", 8'(winner), 8'd0);
        tick();
        repeat (11) tick();
        chk("edge_time", 8'(time_left_s), 8'd1);
        move_valid = 1'b1; tick(); move_valid = 1'b0;
        chk("edge_check", 8'(state_o), 8'd3);
        chk("edge_no_pulse", 8'(timeout_pulse), 8'd0);
        chk("edge_player", 8'(player), 8'd0);
        draw_detected = 1'b1; tick(); draw_detected = 1'b0;
        chk("draw_winner", 8'(winner), 8'd3);
        repeat (5) tick();
        chk("draw_idle", 8'(state_o), 8'd0);

        // P2 move with win and draw both high: win wins
        start = 1'b1; tick(); start = 1'b0;
        tick();
        move_valid = 1'b1; tick(); move_valid = 1'b0;
        tick();
        chk("p2_player", 8'(player), 8'd1);
        move_valid = 1'b1; tick(); move_valid = 1'b0;
        win_detected = 1'b1; draw_detected = 1'b1; tick();
        win_detected = 1'b0; draw_detected = 1'b0;
        chk("prio_p2", 8'(winner), 8'd2);

        // Async reset in RESULT
        tick();
        reset = 1'b1; #2;
        chk("rstres_state", 8'(state_o), 8'd0);
        chk("rstres_winner", 8'(winner), 8'd0);
        chk("rstres_show", 8'(show_result), 8'd0);
        reset = 1'b0;

        // Async reset in TURN
        tick();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("pre_rst_turn", 8'(state_o), 8'd2);
        reset = 1'b1; #2;
        chk("rstturn_state", 8'(state_o), 8'd0);
        chk("rstturn_active", 8'(turn_active), 8'd0);
        chk("rstturn_time", 8'(time_left_s), 8'd0);
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
